// File: rtl/mem_stage.sv
// Pipeline memory stage: byte-addressed little-endian data memory plus the MEM/WB
// register, with misaligned-access detection and a sticky error flag.
module mem_stage #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_ADDR_BITS = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallM,
  input  logic                  FlushM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic                  RegWriteM,
  input  logic                  ResultSrcM,
  input  logic                  MemWriteM,
  input  logic                  addr_modeM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  RegWriteW,
  output logic                  ResultSrcW,
  output logic [4:0]            RdW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [DATA_WIDTH-1:0] PCPlus4W,
  output logic                  MisalignErr,
  output logic [DATA_WIDTH-1:0] FwdResultM
);

  localparam int unsigned MEM_BYTES = 1 << MEM_ADDR_BITS;
  localparam int unsigned WORD_W    = 32;

  logic [7:0] mem [MEM_BYTES];

  logic [MEM_ADDR_BITS-1:0] addr0_c;
  logic [MEM_ADDR_BITS-1:0] addr1_c;
  logic [MEM_ADDR_BITS-1:0] addr2_c;
  logic [MEM_ADDR_BITS-1:0] addr3_c;
  logic [WORD_W-1:0]        wdata_c;
  logic [WORD_W-1:0]        word_c;
  logic [DATA_WIDTH-1:0]    read_data_c;
  logic                     misaligned_c;
  logic                     store_c;

  // Byte lane addresses; upper address bits are dropped so accesses wrap.
  always_comb begin
    addr0_c = ALUResultM[MEM_ADDR_BITS-1:0];
    addr1_c = addr0_c + MEM_ADDR_BITS'(1);
    addr2_c = addr0_c + MEM_ADDR_BITS'(2);
    addr3_c = addr0_c + MEM_ADDR_BITS'(3);
  end

  always_comb begin
    misaligned_c = (MemWriteM || ResultSrcM) && !addr_modeM && (ALUResultM[1:0] != 2'b00);
    store_c      = MemWriteM && !StallM && !FlushM && !misaligned_c;
    wdata_c      = WORD_W'(WriteDataM);
  end

  always_comb begin
    word_c      = {mem[addr3_c], mem[addr2_c], mem[addr1_c], mem[addr0_c]};
    read_data_c = addr_modeM ? DATA_WIDTH'(mem[addr0_c]) : DATA_WIDTH'(word_c);
  end

  assign FwdResultM = ALUResultM;

  // Memory contents survive reset; the reset edge only keeps a store from landing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && store_c) begin
      if (addr_modeM) begin
        mem[addr0_c] <= wdata_c[7:0];
      end else begin
        mem[addr0_c] <= wdata_c[7:0];
        mem[addr1_c] <= wdata_c[15:8];
        mem[addr2_c] <= wdata_c[23:16];
        mem[addr3_c] <= wdata_c[31:24];
      end
    end
  end

  // MEM/WB register: flush beats stall, stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RdW         <= 5'd0;
      ALUResultW  <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
      MisalignErr <= 1'b0;
    end else if (FlushM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      RdW        <= 5'd0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
    end else if (!StallM) begin
      RegWriteW  <= RegWriteM && !misaligned_c;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= read_data_c;
      PCPlus4W   <= PCPlus4M;
      if (misaligned_c) begin
        MisalignErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a vector table and hand-built stall/flush/reset sequences,
// expected W-stage values queued at drive time and compared one edge later.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallM, FlushM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, ResultSrcM, MemWriteM, addr_modeM;
  logic        RegWriteW, ResultSrcW, MisalignErr;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, FwdResultM;

  always #5 clk = ~clk;

  mem_stage #(.DATA_WIDTH(32), .MEM_ADDR_BITS(12)) dut (
    .clk(clk), .rst_n(rst_n), .StallM(StallM), .FlushM(FlushM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .addr_modeM(addr_modeM), .PCPlus4M(PCPlus4M),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .MisalignErr(MisalignErr), .FwdResultM(FwdResultM)
  );

  typedef struct {
    logic        stall, flush, memw, rsrc, regw, mode;
    logic [4:0]  rd;
    logic [31:0] alu, wdata, pc4;
  } stim_t;

  typedef struct {
    string       name;
    logic        regw, rsrc, err, chk_data;
    logic [4:0]  rd;
    logic [31:0] alu, rdata, pc4;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  exp_t        last_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pc_next = 32'h0000_0100;

  // One M-stage record and the W values it must produce; pc4 is a unique tag per record.
  function automatic vec_t mk(string n, logic memw, logic rsrc, logic regw, logic mode,
                              logic [4:0] rd, logic [31:0] alu, logic [31:0] wdata,
                              logic exp_regw, logic exp_err, logic chk, logic [31:0] rdata);
    vec_t v;
    v.s.stall = 1'b0; v.s.flush = 1'b0;
    v.s.memw = memw; v.s.rsrc = rsrc; v.s.regw = regw; v.s.mode = mode;
    v.s.rd = rd; v.s.alu = alu; v.s.wdata = wdata; v.s.pc4 = pc_next;
    v.e.name = n; v.e.regw = exp_regw; v.e.rsrc = rsrc; v.e.err = exp_err;
    v.e.chk_data = chk; v.e.rd = rd; v.e.alu = alu; v.e.rdata = rdata; v.e.pc4 = pc_next;
    pc_next = pc_next + 32'd4;
    return v;
  endfunction

  function automatic exp_t zero_exp(string n, logic err);
    exp_t e;
    e.name = n; e.regw = 1'b0; e.rsrc = 1'b0; e.err = err; e.chk_data = 1'b1;
    e.rd = 5'd0; e.alu = 32'd0; e.rdata = 32'd0; e.pc4 = 32'd0;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    StallM = s.stall; FlushM = s.flush; MemWriteM = s.memw; ResultSrcM = s.rsrc;
    RegWriteM = s.regw; addr_modeM = s.mode; RdM = s.rd; ALUResultM = s.alu;
    WriteDataM = s.wdata; PCPlus4M = s.pc4;
  endtask

  task automatic check_out(input exp_t e);
    logic ok;
    ok = (RegWriteW === e.regw) && (ResultSrcW === e.rsrc) && (RdW === e.rd) &&
         (ALUResultW === e.alu) && (PCPlus4W === e.pc4) && (MisalignErr === e.err) &&
         (!e.chk_data || (ReadDataW === e.rdata));
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got regw=%b src=%b rd=%0d alu=%h rdata=%h pc4=%h err=%b; want regw=%b src=%b rd=%0d alu=%h rdata=%h(chk=%b) pc4=%h err=%b",
               e.name, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, MisalignErr,
               e.regw, e.rsrc, e.rd, e.alu, e.rdata, e.chk_data, e.pc4, e.err);
    end
  endtask

  // Drive on the falling edge, queue the expectation, compare just after the rising edge.
  task automatic cycle(input stim_t s, input exp_t e);
    exp_t got;
    @(negedge clk);
    drive(s);
    #1;
    n_tests++;
    if (FwdResultM !== s.alu) begin
      n_fail++;
      $display("FAIL %s_fwd: got FwdResultM=%h want %h", e.name, FwdResultM, s.alu);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_sb: scoreboard empty", e.name);
    end else begin
      got = sb.pop_front();
      check_out(got);
    end
    last_e = e;
  endtask

  task automatic run(input vec_t v);
    cycle(v.s, v.e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  v;
    stim_t s;
    exp_t  e;

    rst_n = 1'b0;
    drive('{default: '0});
    #2;
    check_out(zero_exp("reset_init", 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //            name          memw rsrc regw mode rd     alu           wdata         eregw err chk rdata
    tbl.push_back(mk("st_w_10",    1, 0, 0, 0, 5'd0,  32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 32'h0));
    tbl.push_back(mk("ld_w_10",    0, 1, 1, 0, 5'd5,  32'h0000_0010, 32'h0,         1, 0, 1, 32'hDEAD_BEEF));
    tbl.push_back(mk("st_b_13",    1, 0, 0, 1, 5'd0,  32'h0000_0013, 32'hFFFF_FFAB, 0, 0, 0, 32'h0));
    tbl.push_back(mk("ld_w_10b",   0, 1, 1, 0, 5'd5,  32'h0000_0010, 32'h0,         1, 0, 1, 32'hABAD_BEEF));
    tbl.push_back(mk("ld_b_13",    0, 1, 1, 1, 5'd7,  32'h0000_0013, 32'h0,         1, 0, 1, 32'h0000_00AB));
    tbl.push_back(mk("ld_b_10",    0, 1, 1, 1, 5'd8,  32'h0000_0010, 32'h0,         1, 0, 1, 32'h0000_00EF));
    tbl.push_back(mk("alu_op",     0, 0, 1, 0, 5'd3,  32'h1234_5679, 32'h0,         1, 0, 0, 32'h0));
    tbl.push_back(mk("st_w_wrap",  1, 0, 0, 0, 5'd0,  32'hABCD_1FFC, 32'hCAFE_F00D, 0, 0, 0, 32'h0));
    tbl.push_back(mk("ld_w_ffc",   0, 1, 1, 0, 5'd9,  32'h0000_0FFC, 32'h0,         1, 0, 1, 32'hCAFE_F00D));
    tbl.push_back(mk("ld_b_fff",   0, 1, 1, 1, 5'd10, 32'hFFFF_FFFF, 32'h0,         1, 0, 1, 32'h0000_00CA));
    tbl.push_back(mk("st_w_20",    1, 0, 0, 0, 5'd0,  32'h0000_0020, 32'h1122_3344, 0, 0, 0, 32'h0));
    tbl.push_back(mk("ld_w_22mis", 0, 1, 1, 0, 5'd6,  32'h0000_0022, 32'h0,         0, 1, 0, 32'h0));
    tbl.push_back(mk("st_w_22mis", 1, 0, 0, 0, 5'd0,  32'h0000_0022, 32'hFFFF_FFFF, 0, 1, 0, 32'h0));
    tbl.push_back(mk("ld_w_20",    0, 1, 1, 0, 5'd4,  32'h0000_0020, 32'h0,         1, 1, 1, 32'h1122_3344));
    tbl.push_back(mk("ld_b_22",    0, 1, 1, 1, 5'd11, 32'h0000_0022, 32'h0,         1, 1, 1, 32'h0000_0022));
    tbl.push_back(mk("st_w_30",    1, 0, 0, 0, 5'd0,  32'h0000_0030, 32'h0102_0304, 0, 1, 0, 32'h0));
    foreach (tbl[i]) run(tbl[i]);

    // Stall three cycles with a store pending: W frozen at the previous record.
    v = mk("stall", 1, 0, 0, 0, 5'd0, 32'h0000_0030, 32'hA5A5_A5A5, 0, 1, 0, 32'h0);
    s = v.s;
    s.stall = 1'b1;
    e = last_e;
    for (int k = 0; k < 3; k++) begin
      e.name = $sformatf("stall_%0d", k);
      cycle(s, e);
    end

    // Flush together with stall and a store: bubble, no write.
    s.flush = 1'b1;
    s.regw  = 1'b1;
    s.rd    = 5'd12;
    cycle(s, zero_exp("flush_stall", 1'b1));

    run(mk("ld_w_30_old", 0, 1, 1, 0, 5'd12, 32'h0000_0030, 32'h0, 1, 1, 1, 32'h0102_0304));
    run(mk("st_w_30_go",  1, 0, 0, 0, 5'd0,  32'h0000_0030, 32'hA5A5_A5A5, 0, 1, 0, 32'h0));
    run(mk("ld_w_30_new", 0, 1, 1, 0, 5'd12, 32'h0000_0030, 32'h0, 1, 1, 1, 32'hA5A5_A5A5));

    // Reset pulse between edges: outputs clear at once, memory survives.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_out(zero_exp("rst_pulse", 1'b0));
    #1 rst_n = 1'b1;
    run(mk("ld_after_rst", 0, 1, 1, 0, 5'd14, 32'h0000_0030, 32'h0, 1, 0, 1, 32'hA5A5_A5A5));

    // Reset held across an edge with a store pending: the store must not land.
    run(mk("st_w_40", 1, 0, 0, 0, 5'd0, 32'h0000_0040, 32'h1111_1111, 0, 0, 0, 32'h0));
    v = mk("st_w_40_rst", 1, 0, 0, 0, 5'd0, 32'h0000_0040, 32'h2222_2222, 0, 0, 0, 32'h0);
    @(negedge clk);
    drive(v.s);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_out(zero_exp("rst_hold_edge", 1'b0));
    rst_n = 1'b1;
    run(mk("ld_w_40", 0, 1, 1, 0, 5'd13, 32'h0000_0040, 32'h0, 1, 0, 1, 32'h1111_1111));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the datapath width in bits.
REQ-002 The block SHALL have parameter MEM_ADDR_BITS, default 12, the byte-address bits of data memory (4 KiB).

Ports (name  direction  width  meaning):
REQ-003 The block SHALL have port clk  in  1  rising-edge clock.
REQ-004 The block SHALL have port rst_n  in  1  reset, asynchronous assert, active-low; the block has one clock only.
REQ-005 The block SHALL have port StallM  in  1  high = hold MEM/WB register and suppress store.
REQ-006 The block SHALL have port FlushM  in  1  high = load a bubble into MEM/WB.
REQ-007 The block SHALL have ports ALUResultM  in  DATA_WIDTH  (byte address / ALU result) and WriteDataM  in  DATA_WIDTH  (store data).
REQ-008 The block SHALL have ports RdM  in  5, RegWriteM  in  1, ResultSrcM  in  1 (1 = load data), MemWriteM  in  1, addr_modeM  in  1 (0 = word, 1 = byte), PCPlus4M  in  DATA_WIDTH.
REQ-009 The block SHALL have ports RegWriteW  out  1, ResultSrcW  out  1, RdW  out  5, ALUResultW  out  DATA_WIDTH, ReadDataW  out  DATA_WIDTH, PCPlus4W  out  DATA_WIDTH.
REQ-010 The block SHALL have port MisalignErr  out  1  sticky misaligned-access flag, and port FwdResultM  out  DATA_WIDTH  (ALUResultM passthrough for forwarding).

Function
REQ-011 Data memory SHALL be an internal byte array of 2^MEM_ADDR_BITS entries, little-endian; only ALUResultM[MEM_ADDR_BITS-1:0] is used, with higher bits ignored (address wraps).
REQ-012 Misaligned SHALL be defined as (MemWriteM or ResultSrcM) and addr_modeM=0 and ALUResultM[1:0]!=0.
REQ-013 A store SHALL commit at the rising edge only when MemWriteM=1, StallM=0, FlushM=0 and the access is not misaligned.
REQ-014 A word store SHALL write 4 bytes at addr..addr+3; a byte store SHALL write WriteDataM[7:0] to addr only.
REQ-015 Read data SHALL be combinational from the array: word = {b[a+3],b[a+2],b[a+1],b[a]}; byte = zero-extended b[a].
REQ-016 The MEM/WB register SHALL capture read data and all M-stage fields at each rising edge when StallM=0 and FlushM=0, giving 1-cycle latency from M to W.
REQ-017 When FlushM=1, the block SHALL load RegWriteW=0, ResultSrcW=0, RdW=0, and leave the data fields don't-care (implemented as 0); FlushM has priority over StallM.
REQ-018 When StallM=1 and FlushM=0, all W outputs SHALL hold their values and no store is performed.
REQ-019 A misaligned access captured into W SHALL force RegWriteW=0 and set MisalignErr=1, which then holds until reset.
REQ-020 A load issued in the cycle after a store to the same address SHALL return the newly stored data; no bypass is needed because the write completes at the edge that precedes the read.
REQ-021 FwdResultM SHALL equal ALUResultM combinationally.

Reset
REQ-022 While rst_n=0, all W outputs and MisalignErr SHALL be 0, asynchronously; memory contents are not reset.
REQ-023 Reset asserted mid-store SHALL block the store at any edge where rst_n=0; the first capture and store occur at the first rising edge after rst_n rises.

Verification
REQ-024 Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 with RdM=5 -> one cycle later ReadDataW=0xDEADBEEF, RdW=5, RegWriteW=1.
REQ-025 Byte store 0xAB to addr 0x13 over the above, then word load 0x10 -> 0xABADBEEF; byte load 0x13 -> 0x000000AB.
REQ-026 Word load at addr 0x22 -> RegWriteW=0, MisalignErr=1 and it stays 1; word store at 0x22 -> memory unchanged.
REQ-027 StallM=1 for 3 cycles with a store pending -> W outputs frozen and no write; store commits on the first unstalled edge.
REQ-028 FlushM=1 together with StallM=1 and a store -> RegWriteW=0, RdW=0, no write.
REQ-029 rst_n pulsed low between clock edges -> outputs and MisalignErr go to 0 immediately; previously stored memory data is still readable afterwards.
